rca_accumulator_8: RTL and testbench

//  Sequential accumulator sitting directly downstream of the 8-bit ripple-carry adder fa_rca_8.

---
 rtl/rca_accumulator_8_pkg.sv | 20 ++
 rtl/rca_accumulator_8_fa_rca_8.sv | 31 +++
 rtl/rca_accumulator_8.sv | 112 +++++++++++
 tb/tb_rca_accumulator_8.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rca_accumulator_8_pkg.sv
// ============================================================================
// Module   : rca_accumulator_8_pkg
// Brief    : Shared state encoding and datapath width for rca_accumulator_8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rca_accumulator_8_pkg;

    localparam int c_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rca_accumulator_8_fa_rca_8.sv
// ============================================================================
// Module   : fa_rca_8
// Brief    : 8-bit ripple-carry adder built from a chain of full adders.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_rca_8
    import rca_accumulator_8_pkg::*;
(
    input  logic [c_DATA_W-1:0] a_i,
    input  logic [c_DATA_W-1:0] b_i,
    input  logic                cin_i,
    output logic [c_DATA_W-1:0] sum_o,
    output logic                carry_o
);

    logic [c_DATA_W:0] w_c;

    assign w_c[0] = cin_i;

    for (genvar i = 0; i < c_DATA_W; i++) begin : g_bit
        assign sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
        assign w_c[i+1]  = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
    end

    assign carry_o = w_c[c_DATA_W];

endmodule

`default_nettype wire

// File: rtl/rca_accumulator_8.sv
// ============================================================================
// Module   : rca_accumulator_8
// Brief    : Packet accumulator around fa_rca_8 with valid/ready in and out.
//            Define SATURATE_EN to clamp the sum at 8'hFF after any carry-out.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_accumulator_8
    import rca_accumulator_8_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int COUNT_W   = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [c_DATA_W-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [c_DATA_W-1:0] out_sum,
    output logic                out_carry,
    output logic [COUNT_W-1:0]  out_count
);

    state_e                state_q, state_d;
    logic [c_DATA_W-1:0]   acc_q, acc_d;
    logic                  carry_q, carry_d;
    logic [COUNT_W-1:0]    count_q, count_d;

    logic [c_DATA_W-1:0]   w_add_sum;
    logic                  w_add_carry;
    logic [c_DATA_W-1:0]   w_acc_next;
    logic [COUNT_W-1:0]    w_count_inc;
    logic                  w_accept;
    logic                  w_hit_max;

    fa_rca_8 u_fa_rca_8 (
        .a_i     (acc_q),
        .b_i     (in_data),
        .cin_i   (1'b0),
        .sum_o   (w_add_sum),
        .carry_o (w_add_carry)
    );

    assign in_ready    = (state_q != HOLD);
    assign out_valid   = (state_q == HOLD);
    assign out_sum     = acc_q;
    assign out_carry   = carry_q;
    assign out_count   = count_q;

    assign w_accept    = in_valid && in_ready;
    assign w_count_inc = count_q + COUNT_W'(1);
    assign w_hit_max   = (w_count_inc == COUNT_W'(MAX_BEATS));

`ifdef SATURATE_EN
    // Once any carry has occurred the sum is pinned at all-ones for the packet.
    assign w_acc_next = (carry_q || w_add_carry) ? {c_DATA_W{1'b1}} : w_add_sum;
`else
    assign w_acc_next = w_add_sum;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    acc_d   = w_acc_next;
                    carry_d = carry_q | w_add_carry;
                    count_d = w_count_inc;
                    state_d = (in_last || w_hit_max) ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                carry_d = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rca_accumulator_8.sv
// ============================================================================
// Module   : tb_rca_accumulator_8
// Brief    : Directed and randomized self-checking bench for rca_accumulator_8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rca_accumulator_8;

    localparam int MAX_BEATS = 16;
    localparam int COUNT_W   = $clog2(MAX_BEATS + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_sum;
    logic               out_carry;
    logic [COUNT_W-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    rca_accumulator_8 #(.MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit v, input logic [7:0] s,
                           input bit c, input int n);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_ready"}, 32'(in_ready), 32'(!v));
        chk({tag, "_sum"},   32'(out_sum), 32'(s));
        chk({tag, "_carry"}, 32'(out_carry), 32'(c));
        chk({tag, "_count"}, 32'(out_count), n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last);
        chk("beat_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'($urandom);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Reference: plain integer sum with overflow detection per beat.
    task automatic model(input logic [7:0] q[$], output logic [7:0] s, output bit c);
        int total;
        total = 0;
        c     = 1'b0;
        foreach (q[i]) begin
            total = total + int'(q[i]);
            if (total > 255) begin
                c     = 1'b1;
                total = total - 256;
            end
        end
`ifdef SATURATE_EN
        s = c ? 8'hFF : 8'(total);
`else
        s = 8'(total);
`endif
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] es;
        bit         ec;
        int         n, nb;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        chk_out("reset", 1'b0, 8'h00, 1'b0, 0);
        rst = 1'b0;
        tick();

        send_beat(8'h00, 1'b0);
        chk("t2_mid_valid", 32'(out_valid), 32'd0);
        send_beat(8'h01, 1'b1);
        chk_out("t2", 1'b1, 8'h01, 1'b0, 2);
        release_result("t2");
        tick();

        send_beat(8'h77, 1'b0);
        send_beat(8'h55, 1'b1);
        chk_out("t3", 1'b1, 8'hCC, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; out_ready = 1'b0;
            tick();
            chk_out("t5_hold", 1'b1, 8'hCC, 1'b0, 2);
        end
        in_valid = 1'b0; in_last = 1'b0;
        release_result("t5");
        tick();

        send_beat(8'h8C, 1'b0);
        send_beat(8'h74, 1'b1);
`ifdef SATURATE_EN
        chk_out("t4", 1'b1, 8'hFF, 1'b1, 2);
`else
        chk_out("t4", 1'b1, 8'h00, 1'b1, 2);
`endif
        release_result("t4");
        tick();

        for (int i = 0; i < MAX_BEATS; i++) begin
            if (i == MAX_BEATS - 1) chk("t6_pre_valid", 32'(out_valid), 32'd0);
            send_beat(8'h01, 1'b0);
        end
        chk_out("t6", 1'b1, 8'h10, 1'b0, MAX_BEATS);
        release_result("t6");
        tick();

        for (int i = 0; i < 5; i++) send_beat(8'h01, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("t6_rst", 1'b0, 8'h00, 1'b0, 0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b1);
        chk_out("t6_post", 1'b1, 8'h55, 1'b0, 2);
        release_result("t6_post");
        tick();

        for (int p = 0; p < 25; p++) begin
            n  = int'($urandom_range(1, 24));
            nb = (n > MAX_BEATS) ? MAX_BEATS : n;
            q.delete();
            for (int b = 0; b < nb; b++) q.push_back(8'($urandom));
            model(q, es, ec);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid  = 1'b0;
                    in_last   = 1'($urandom);
                    out_ready = 1'($urandom);
                    tick();
                    in_last   = 1'b0;
                end
                send_beat(q[b], (b == nb - 1) && (n <= MAX_BEATS));
            end
            chk_out("rand", 1'b1, es, ec, nb);
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b0;
                tick();
                in_valid = 1'b0;
                chk_out("rand_hold", 1'b1, es, ec, nb);
            end
            release_result("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
